// File: rtl/pattern_detector_moore_pkg.sv
// Shared types and defaults for the pattern_detector_moore slice.
// Optional match counter is enabled by defining MATCH_COUNT_EN.
package pattern_detector_moore_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2,
    LOCK = 2'd3
  } state_t;

  localparam int unsigned DEF_PAT_W    = 4;
  localparam logic [3:0]  DEF_PAT_INIT = 4'b1001;
  localparam int unsigned DEF_CNT_W    = 8;

endpackage

// File: rtl/pattern_shift_window.sv
// Serial history window with fill counter, pattern compare and restart/clear control.
module pattern_shift_window #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             shift,
  input  logic             inbit,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             match,
  output logic             full
);

  localparam int unsigned FW = $clog2(PAT_W + 1);

  // The oldest history bit is shifted out before it could ever be compared,
  // so only PAT_W-1 bits are stored; the compare uses the updated window.
  logic [PAT_W-2:0] history;
  logic [PAT_W-1:0] hist_next;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;

  always_comb begin
    hist_next = {history, inbit};
    fill_next = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    full      = (fill_next == FW'(PAT_W));
    match     = full && (hist_next == pattern);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
    end else if (restart) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      if (match && !overlap) begin
        history <= '0;
        fill    <= '0;
      end else begin
        history <= hist_next[PAT_W-2:0];
        fill    <= fill_next;
      end
    end
  end

endmodule

// File: rtl/pattern_detector_moore.sv
// Runtime-programmable Moore serial pattern detector (FSM, pattern register, counter).
// Define MATCH_COUNT_EN to add the saturating match_count output.
module pattern_detector_moore
  import pattern_detector_moore_pkg::*;
#(
  parameter int unsigned      PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_INIT)
`ifdef MATCH_COUNT_EN
  , parameter int unsigned    CNT_W    = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inbit,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic             mode_overlap,
  input  logic             mode_sticky,
  output logic             ans
`ifdef MATCH_COUNT_EN
  , output logic [CNT_W-1:0] match_count
`endif
);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pattern;
  logic             accept;
  logic             match;
  logic             full;

  // LOCK ignores the stream entirely, so the window and counter freeze too.
  assign accept = in_valid && !pat_load && (state != LOCK);

  pattern_shift_window #(
    .PAT_W(PAT_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .restart (pat_load),
    .shift   (accept),
    .inbit   (inbit),
    .overlap (mode_overlap),
    .pattern (pattern),
    .match   (match),
    .full    (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= PAT_INIT;
    end else if (pat_load) begin
      pattern <= pat_value;
    end
  end

  // A non-matching bit lands in SCAN only once the window is full again;
  // after a non-overlapping clear that returns HIT to FILL.
  always_comb begin
    state_next = state;
    if (pat_load) begin
      state_next = FILL;
    end else if (accept) begin
      if (match) begin
        state_next = mode_sticky ? LOCK : HIT;
      end else begin
        state_next = full ? SCAN : FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  assign ans = (state == HIT) || (state == LOCK);

`ifdef MATCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (accept && match && (match_count != '1)) begin
      match_count <= match_count + 1'b1;
    end
  end
`endif

endmodule
